// File: rtl/vehicle_control_pkg.sv
// Shared types and code constants for the vehicle body-control block.
// Optional feature macro used by the top: VEHICLE_CTRL_REV_INTERLOCK_EN.
package vehicle_control_pkg;

  typedef enum logic [1:0] {
    LOCK    = 2'b00,
    PARKING = 2'b01,
    REVERSE = 2'b10,
    FORWARD = 2'b11
  } gear_e;

  typedef enum logic [1:0] {
    NO_TURN    = 2'b00,
    LEFT_TURN  = 2'b01,
    RIGHT_TURN = 2'b11
  } turn_e;

  localparam logic [1:0] LeverNeutral = 2'b00;
  localparam logic [1:0] LeverLeft    = 2'b01;
  localparam logic [1:0] LeverRight   = 2'b10;

  localparam logic [1:0] GearReqPark    = 2'b00;
  localparam logic [1:0] GearReqReverse = 2'b01;
  localparam logic [1:0] GearReqHold    = 2'b10;
  localparam logic [1:0] GearReqForward = 2'b11;

endpackage

// File: rtl/turn_signal_fsm.sv
// Turn-indicator state machine: lever edge detector plus NO_TURN/LEFT/RIGHT state register.
module turn_signal_fsm
  import vehicle_control_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] lever_i,
  input  logic       turn_enable_i,
  output logic [1:0] turn_state_o
);

  turn_e      state_q, state_d;
  logic [1:0] prev_q;
  logic       left_evt, right_evt;

  // prev_q tracks the lever every cycle so a held lever yields a single event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= NO_TURN;
      prev_q  <= LeverNeutral;
    end else begin
      state_q <= state_d;
      prev_q  <= lever_i;
    end
  end

  always_comb begin
    left_evt  = (lever_i == LeverLeft) && (lever_i != prev_q);
    right_evt = (lever_i == LeverRight) && (lever_i != prev_q);
  end

  always_comb begin
    state_d = state_q;
    if (!turn_enable_i) begin
      state_d = NO_TURN;
    end else if (right_evt) begin
      state_d = (state_q == LEFT_TURN) ? NO_TURN : RIGHT_TURN;
    end else if (left_evt) begin
      state_d = (state_q == RIGHT_TURN) ? NO_TURN : LEFT_TURN;
    end
  end

  assign turn_state_o = state_q;

endmodule

// File: rtl/vehicle_control.sv
// Vehicle body control: ignition-gated gear FSM plus turn-indicator sub-FSM.
// Macro VEHICLE_CTRL_REV_INTERLOCK_EN blocks direct FORWARD<->REVERSE requests.
module vehicle_control
  import vehicle_control_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       _switch,
  input  logic [1:0] _turnShift,
  input  logic [1:0] _gearShift,
  output logic [1:0] _turnState,
  output logic [1:0] _gearState
);

  gear_e gear_q, gear_d;
  logic  turn_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      gear_q <= LOCK;
    end else begin
      gear_q <= gear_d;
    end
  end

  always_comb begin
    gear_d = gear_q;
    if (!_switch) begin
      gear_d = LOCK;
    end else if (gear_q == LOCK) begin
      gear_d = PARKING;
    end else begin
      unique case (_gearShift)
        GearReqPark:    gear_d = PARKING;
        GearReqReverse: begin
`ifdef VEHICLE_CTRL_REV_INTERLOCK_EN
          if (gear_q != FORWARD) gear_d = REVERSE;
`else
          gear_d = REVERSE;
`endif
        end
        GearReqForward: begin
`ifdef VEHICLE_CTRL_REV_INTERLOCK_EN
          if (gear_q != REVERSE) gear_d = FORWARD;
`else
          gear_d = FORWARD;
`endif
        end
        GearReqHold:    gear_d = gear_q;
        default:        gear_d = gear_q;
      endcase
    end
  end

  // Turn logic follows the gear being entered, so a shift into PARKING clears it the same edge.
  always_comb begin
    turn_enable = (gear_d == REVERSE) || (gear_d == FORWARD);
    _gearState  = gear_q;
  end

  turn_signal_fsm u_turn_signal_fsm (
    .clk_i         (clock),
    .rst_i         (reset),
    .lever_i       (_turnShift),
    .turn_enable_i (turn_enable),
    .turn_state_o  (_turnState)
  );

endmodule

// File: tb/tb_vehicle_control.sv
// Directed self-checking bench for vehicle_control with hand-computed expectations.
module tb_vehicle_control;

  logic       clock;
  logic       reset;
  logic       sw;
  logic [1:0] turn_shift;
  logic [1:0] gear_shift;
  logic [1:0] turn_state;
  logic [1:0] gear_state;

  int total = 0;
  int bad   = 0;

  vehicle_control dut (
    .clock      (clock),
    .reset      (reset),
    ._switch    (sw),
    ._turnShift (turn_shift),
    ._gearShift (gear_shift),
    ._turnState (turn_state),
    ._gearState (gear_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic s, input logic [1:0] t, input logic [1:0] g);
    sw         = s;
    turn_shift = t;
    gear_shift = g;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] exp_gear, input logic [1:0] exp_turn);
    total++;
    assert (gear_state === exp_gear) else begin
      bad++;
      $error("FAIL %s gear observed=%b expected=%b", tag, gear_state, exp_gear);
    end
    total++;
    assert (turn_state === exp_turn) else begin
      bad++;
      $error("FAIL %s turn observed=%b expected=%b", tag, turn_state, exp_turn);
    end
  endtask

  initial begin
    reset = 1'b1;
    step(1'b0, 2'b00, 2'b10);
    step(1'b0, 2'b00, 2'b10);
    check("reset", 2'b00, 2'b00);

    reset = 1'b0;
    step(1'b0, 2'b00, 2'b00);
    step(1'b0, 2'b00, 2'b00);
    step(1'b0, 2'b00, 2'b00);
    check("ign_off_3cyc", 2'b00, 2'b00);

    // Gear request on the ignition-on edge is ignored.
    step(1'b1, 2'b00, 2'b01);
    check("ign_on_park", 2'b01, 2'b00);
    step(1'b1, 2'b00, 2'b01);
    check("to_reverse", 2'b10, 2'b00);
    step(1'b1, 2'b00, 2'b11);
`ifdef VEHICLE_CTRL_REV_INTERLOCK_EN
    check("rev_to_fwd", 2'b10, 2'b00);
`else
    check("rev_to_fwd", 2'b11, 2'b00);
`endif
    step(1'b1, 2'b00, 2'b00);
    check("to_park", 2'b01, 2'b00);
    step(1'b1, 2'b00, 2'b11);
    check("park_to_fwd", 2'b11, 2'b00);

    step(1'b1, 2'b10, 2'b10);
    check("right_push", 2'b11, 2'b11);
    step(1'b1, 2'b10, 2'b10);
    step(1'b1, 2'b10, 2'b10);
    check("right_held", 2'b11, 2'b11);
    step(1'b1, 2'b00, 2'b10);
    check("right_release", 2'b11, 2'b11);
    step(1'b1, 2'b01, 2'b10);
    check("left_cancels_right", 2'b11, 2'b00);
    step(1'b1, 2'b00, 2'b10);
    step(1'b1, 2'b01, 2'b10);
    check("left_push", 2'b11, 2'b01);
    step(1'b1, 2'b10, 2'b10);
    check("right_cancels_left", 2'b11, 2'b00);
    step(1'b1, 2'b00, 2'b10);
    step(1'b1, 2'b10, 2'b10);
    check("right_again", 2'b11, 2'b11);

    step(1'b1, 2'b00, 2'b10);
    step(1'b1, 2'b10, 2'b00);
    check("park_with_edge", 2'b01, 2'b00);

    step(1'b1, 2'b00, 2'b01);
    check("park_to_rev", 2'b10, 2'b00);
    step(1'b1, 2'b01, 2'b10);
    check("rev_left", 2'b10, 2'b01);
    step(1'b0, 2'b01, 2'b10);
    check("ign_off_rev_left", 2'b00, 2'b00);
    step(1'b1, 2'b00, 2'b10);
    check("ign_on_again", 2'b01, 2'b00);

    step(1'b1, 2'b10, 2'b11);
    check("fwd_right_same_edge", 2'b11, 2'b11);
    reset = 1'b1;
    step(1'b1, 2'b10, 2'b11);
    check("mid_reset", 2'b00, 2'b00);
    reset = 1'b0;
    step(1'b1, 2'b10, 2'b10);
    check("post_reset_park", 2'b01, 2'b00);
    step(1'b1, 2'b10, 2'b11);
    check("held_lever_no_evt", 2'b11, 2'b00);
    step(1'b1, 2'b10, 2'b10);
    check("held_lever_still", 2'b11, 2'b00);
    step(1'b1, 2'b00, 2'b10);
    step(1'b1, 2'b10, 2'b10);
    check("lever_reedge", 2'b11, 2'b11);

    step(1'b1, 2'b11, 2'b10);
    check("invalid_lever", 2'b11, 2'b11);
    step(1'b1, 2'b01, 2'b10);
    check("left_after_invalid", 2'b11, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
